// File: rtl/rv32_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shared 32-step shift-add / restoring-divide
// datapath behind valid/ready handshakes, with ISA-exact divide-by-zero and overflow results.
module rv32_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int unsigned      CNT_W     = 6;
    localparam int unsigned      ACC_W     = 2 * XLEN;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  res_q, res_d;

    // Operand signedness and magnitudes, decoded from the incoming funct3
    logic            rs1_signed, rs2_signed, sign_a, sign_b, is_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    assign rs1_signed = in_funct3[2] ? ~in_funct3[0] : (in_funct3[1:0] != 2'b11);
    assign rs2_signed = in_funct3[2] ? ~in_funct3[0] : ~in_funct3[1];
    assign sign_a     = rs1_signed & in_rs1[XLEN-1];
    assign sign_b     = rs2_signed & in_rs2[XLEN-1];
    assign mag_a      = sign_a ? -in_rs1 : in_rs1;
    assign mag_b      = sign_b ? -in_rs2 : in_rs2;
    assign is_ovf     = ~in_funct3[0] & (in_rs1 == MOST_NEG) & (&in_rs2);

    // acc holds {high, low}: product/multiplier for MUL, remainder/dividend-quotient for DIV
    logic [XLEN:0]    mul_sum, div_shift, div_trial;
    logic             div_ge;
    logic [ACC_W-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]  quo, rem, mul_res, div_res;

    assign mul_sum   = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_trial[XLEN];
    assign div_next  = {div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0],
                        acc_q[XLEN-2:0], div_ge};

    // Sign correction applied on the final step
    assign prod    = (sa_q ^ sb_q) ? -mul_next : mul_next;
    assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
    assign quo     = div_next[XLEN-1:0];
    assign rem     = div_next[ACC_W-1:XLEN];
    assign div_res = op_q[1] ? (sa_q ? -rem : rem) : ((sa_q ^ sb_q) ? -quo : quo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            tag_q <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            op_q  <= op_d;
            tag_q <= tag_d;
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            res_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d  = in_funct3[1:0];
                        tag_d = in_tag;
                        sa_d  = sign_a;
                        sb_d  = sign_b;
                        b_d   = mag_b;
                        acc_d = {{XLEN{1'b0}}, mag_a};
                        cnt_d = '0;
                        if (!in_funct3[2]) begin
                            state_d = S_MUL;
                        end else if (in_rs2 == '0) begin
                            state_d = S_DONE;
                            res_d   = in_funct3[1] ? in_rs1 : '1;
                        end else if (is_ovf) begin
                            state_d = S_DONE;
                            res_d   = in_funct3[1] ? '0 : MOST_NEG;
                        end else begin
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        res_d   = mul_res;
                    end
                end
                S_DIV: begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        res_d   = div_res;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        res_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        out_result = res_q;
        out_tag    = tag_q;
    end

endmodule

// File: tb/tb_rv32_muldiv_seq.sv
// Self-checking bench for rv32_muldiv_seq: directed ISA corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_rv32_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    rv32_muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit integer arithmetic with the ISA's divide special cases
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin pu = ua * ub; return pu[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pu = ua / ub; return pu[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = ua % ub; return pu[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Issue one op, wait (bounded) for the result, then consume it; lat = -1 on timeout
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, output logic [31:0] res, output logic [4:0] rtag,
                         output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_tag = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res  = out_result;
        rtag = out_tag;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
        checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected 1/0", in_ready, busy); end
    endtask

    task automatic test_directed();
        logic [2:0]  f3s  [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd7, 3'd4, 3'd6, 3'd6, 3'd4, 3'd5};
        logic [31:0] as   [11] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd5,
                                   32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
        logic [31:0] bs   [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7};
        logic [31:0] exps [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd14};
        int          lats [11] = '{33, 33, 33, 33, 1, 1, 1, 1, 33, 33, 33};
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            do_op(f3s[i], as[i], bs[i], 5'(i + 10), res, rtag, lat);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, exps[i]); end
            checks++; if (lat != lats[i]) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, lats[i]); end
            checks++; if (rtag !== 5'(i + 10)) begin errors++; $display("FAIL directed_tag[%0d]: got %h expected %h", i, rtag, 5'(i + 10)); end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 255));
        return $urandom;
    endfunction

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        logic [4:0]  tg, rtag;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            tg  = 5'($urandom);
            exp = ref_model(f3, a, b);
            do_op(f3, a, b, tg, res, rtag, lat);
            checks++; if (res !== exp) begin errors++; $display("FAIL random_result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp); end
            checks++; if (lat != ref_latency(f3, a, b)) begin errors++; $display("FAIL random_latency f3=%0d: got %0d expected %0d", f3, lat, ref_latency(f3, a, b)); end
            checks++; if (rtag !== tg) begin errors++; $display("FAIL random_tag: got %h expected %h", rtag, tg); end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b101; in_rs1 = 32'd100; in_rs2 = 32'd7; in_tag = 5'h15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_timeout: got %b expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd3; in_rs2 = 32'd3; in_tag = 5'h03;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_result !== 32'd14 || out_tag !== 5'h15 || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b res=%h tag=%h ready=%b expected 1/0000000e/15/0", i, out_valid, out_result, out_tag, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL bp_release: got valid=%b ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL bp_result_cleared: got %h expected 0", out_result); end
    endtask

    task automatic test_flush();
        logic seen;
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 5'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_started: got busy=%b expected 1", busy); end
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL flush_mul_idle: got busy=%b ready=%b valid=%b expected 0/1/0", busy, in_ready, out_valid); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_output: got out_valid seen=%b expected 0", seen); end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'b100; in_rs1 = 32'd1; in_rs2 = 32'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: got busy=%b valid=%b expected 0/0", busy, out_valid); end
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flush_setup_done: got valid=%b res=%h expected 1/ffffffff", out_valid, out_result); end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_in_done: got valid=%b res=%h ready=%b expected 0/0/1", out_valid, out_result, in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, exp;
        logic [4:0]  rtag;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b100; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_tag = 5'h1F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'h0)
            begin errors++; $display("FAIL async_reset: got ready=%b valid=%b busy=%b res=%h tag=%h expected 1/0/0/0/0", in_ready, out_valid, busy, out_result, out_tag); end
        @(negedge clk);
        rst = 1'b0;
        exp = ref_model(3'b100, 32'd1000, 32'hFFFF_FFFD);
        do_op(3'b100, 32'd1000, 32'hFFFF_FFFD, 5'h11, res, rtag, lat);
        checks++; if (res !== exp || rtag !== 5'h11 || lat != 33)
            begin errors++; $display("FAIL after_reset_op: got res=%h tag=%h lat=%0d expected %h/11/33", res, rtag, lat, exp); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
